// File: rtl/intc_pkg.sv
// ============================================================
// Module : intc_pkg
// Desc   : shared port offsets and FSM encodings for intc
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

package intc_pkg;

   localparam logic [7:0] c_off_mask = 8'd0;
   localparam logic [7:0] c_off_pend = 8'd1;
   localparam logic [7:0] c_off_isr  = 8'd2;

   localparam int c_idx_w = 4;

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_req     = 2'd1;
   localparam logic [1:0] c_st_service = 2'd2;

endpackage

`default_nettype wire

// File: rtl/intc_prio.sv
// ============================================================
// Module : intc_prio
// Desc   : lowest-index-wins priority encoder (combinational)
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module intc_prio
   import intc_pkg::*;
#(
   parameter int CHANNELS = 8
) (
   input  logic [CHANNELS-1:0] i_req,
   output logic [c_idx_w-1:0]  o_idx,
   output logic                o_valid
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = c_idx_w'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/intc.sv
// ============================================================
// Module : intc
// Desc   : edge-triggered interrupt controller, 3-port CPU I/F
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module intc
   import intc_pkg::*;
#(
   parameter int         CHANNELS  = 8,
   parameter logic [7:0] PORT_BASE = 8'h10,
   parameter logic [3:0] VECT_BASE = 4'h0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] src,
   input  logic [7:0]          address,
   input  logic [7:0]          out,
   input  logic                port_we,
   input  logic                port_rd,
   output logic [7:0]          pin,
   input  logic                iff1,
   output logic                irq,
   output logic [3:0]          vect
);

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [CHANNELS-1:0] r_mask;
   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] r_src_d;
   logic                r_iff1_d;
   logic                r_in_service;
   logic [c_idx_w-1:0]  r_active;

   logic                w_sel_mask;
   logic                w_sel_pend;
   logic                w_sel_isr;
   logic                w_eoi;
   logic [CHANNELS-1:0] w_edge;
   logic [CHANNELS-1:0] w_w1c;
   logic [CHANNELS-1:0] w_mask_nxt;
   logic [CHANNELS-1:0] w_pend_kept;
   logic [CHANNELS-1:0] w_clr_act;
   logic [7:0]          w_mask8;
   logic [7:0]          w_pend8;
   logic                w_withdraw;
   logic                w_accept;
   logic [c_idx_w-1:0]  w_win_idx;
   logic                w_win_vld;
   logic                w_unused;

   // Reads are purely address-decoded, so the read strobe carries no information here.
   assign w_unused = port_rd;

   assign w_sel_mask = (address == PORT_BASE + c_off_mask);
   assign w_sel_pend = (address == PORT_BASE + c_off_pend);
   assign w_sel_isr  = (address == PORT_BASE + c_off_isr);
   assign w_eoi      = port_we && w_sel_isr;

   assign w_edge      = src & ~r_src_d;
   assign w_w1c       = (port_we && w_sel_pend) ? out[CHANNELS-1:0] : '0;
   assign w_mask_nxt  = (port_we && w_sel_mask) ? out[CHANNELS-1:0] : r_mask;
   assign w_pend_kept = (r_pend & ~w_w1c) | w_edge;
   assign w_mask8     = 8'(w_mask_nxt);
   assign w_pend8     = 8'(w_pend_kept);

   // Withdrawal looks at the post-write values so a mask/W1C write drops irq at its own edge.
   assign w_withdraw = (r_state == c_st_req) &&
                       !(w_mask8[r_active[2:0]] && w_pend8[r_active[2:0]]);
   assign w_accept   = (r_state == c_st_req) && !w_withdraw && r_iff1_d && !iff1;
   assign w_clr_act  = CHANNELS'(w_accept) << r_active;

   intc_prio #(
      .CHANNELS (CHANNELS)
   ) u_prio (
      .i_req   (r_pend & r_mask),
      .o_idx   (w_win_idx),
      .o_valid (w_win_vld)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mask       <= '0;
         r_pend       <= '0;
         r_src_d      <= src;
         r_iff1_d     <= 1'b0;
         r_in_service <= 1'b0;
         r_active     <= '0;
      end else begin
         r_mask   <= w_mask_nxt;
         r_src_d  <= src;
         r_iff1_d <= iff1;
         // A fresh edge beats both W1C and the acceptance clear on the same bit.
         r_pend   <= (r_pend & ~w_w1c & ~w_clr_act) | w_edge;
         if (r_state == c_st_idle && w_win_vld) begin
            r_active <= w_win_idx;
         end
         if (w_accept) begin
            r_in_service <= 1'b1;
         end else if (r_state == c_st_service && w_eoi) begin
            r_in_service <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_win_vld) w_state_nxt = c_st_req;
         end
         c_st_req: begin
            if (w_withdraw)    w_state_nxt = c_st_idle;
            else if (w_accept) w_state_nxt = c_st_service;
         end
         c_st_service: begin
            if (w_eoi) w_state_nxt = c_st_idle;
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      irq  = (r_state == c_st_req);
      vect = VECT_BASE + r_active;
   end

   always_comb begin
      pin = 8'h00;
      if (w_sel_mask)      pin = 8'(r_mask);
      else if (w_sel_pend) pin = 8'(r_pend);
      else if (w_sel_isr)  pin = {r_in_service, 3'b000, r_active};
   end

endmodule

`default_nettype wire

// File: tb/tb_intc.sv
// ============================================================
// Module : tb_intc
// Desc   : scoreboard bench for intc (default parameters)
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module tb_intc;

   localparam logic [7:0] c_mask = 8'h10;
   localparam logic [7:0] c_pend = 8'h11;
   localparam logic [7:0] c_isr  = 8'h12;

   localparam int c_k_pin  = 0;
   localparam int c_k_irq  = 1;
   localparam int c_k_vect = 2;

   logic       clock;
   logic       reset;
   logic [7:0] src;
   logic [7:0] address;
   logic [7:0] out;
   logic       port_we;
   logic       port_rd;
   logic [7:0] pin;
   logic       iff1;
   logic       irq;
   logic [3:0] vect;

   typedef struct {
      string      tag;
      int         kind;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   intc dut (
      .clock   (clock),
      .reset   (reset),
      .src     (src),
      .address (address),
      .out     (out),
      .port_we (port_we),
      .port_rd (port_rd),
      .pin     (pin),
      .iff1    (iff1),
      .irq     (irq),
      .vect    (vect)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int kind, input logic [7:0] exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [7:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            c_k_pin:  obs = pin;
            c_k_irq:  obs = {7'b0, irq};
            default:  obs = {4'b0, vect};
         endcase
         chk(e.tag, obs, e.exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      address = a;
      out     = d;
      port_we = 1'b1;
      tick(1);
      port_we = 1'b0;
      address = 8'h00;
      out     = 8'h00;
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      address = a;
      port_rd = 1'b1;
      #1;
      push(tag, c_k_pin, exp);
      drain();
      port_rd = 1'b0;
      address = 8'h00;
   endtask

   task automatic exp_req(input string tag, input logic [3:0] v);
      push({tag, "_irq"}, c_k_irq, 8'h01);
      push({tag, "_vect"}, c_k_vect, {4'h0, v});
   endtask

   initial begin
      reset   = 1'b1;
      src     = 8'h00;
      address = 8'h00;
      out     = 8'h00;
      port_we = 1'b0;
      port_rd = 1'b0;
      iff1    = 1'b1;
      tick(3);
      push("rst_irq", c_k_irq, 8'h00);
      push("rst_vect", c_k_vect, 8'h00);
      drain();
      rd("rst_mask", c_mask, 8'h00);
      reset = 1'b0;
      tick(1);
      rd("rst_pend", c_pend, 8'h00);
      rd("rst_isr", c_isr, 8'h00);

      // Basic request/accept/EOI on channel 2
      wr(c_mask, 8'h05);
      rd("t1_mask", c_mask, 8'h05);
      rd("t1_outside_hi", 8'h13, 8'h00);
      rd("t1_outside_lo", 8'h0F, 8'h00);
      src = 8'h04;
      push("t1_irq_early", c_k_irq, 8'h00);
      tick(1);
      drain();
      src = 8'h00;
      exp_req("t1_req", 4'd2);
      tick(1);
      drain();
      iff1 = 1'b0;
      push("t1_irq_acc", c_k_irq, 8'h00);
      tick(1);
      drain();
      rd("t1_isr", c_isr, 8'h82);
      rd("t1_pend", c_pend, 8'h00);
      iff1 = 1'b1;
      wr(c_isr, 8'h00);
      rd("t1_isr_eoi", c_isr, 8'h02);

      // Simultaneous ch1/ch3: lower index first, ch3 after EOI
      wr(c_mask, 8'hFF);
      src = 8'h0A;
      tick(1);
      src = 8'h00;
      exp_req("t2_first", 4'd1);
      tick(1);
      drain();
      iff1 = 1'b0;
      tick(1);
      rd("t2_isr", c_isr, 8'h81);
      push("t2_svc_irq", c_k_irq, 8'h00);
      tick(2);
      drain();
      wr(c_isr, 8'h00);
      exp_req("t2_second", 4'd3);
      tick(1);
      drain();
      iff1 = 1'b1;
      tick(1);
      iff1 = 1'b0;
      tick(1);
      rd("t2_isr2", c_isr, 8'h83);
      wr(c_isr, 8'h00);
      iff1 = 1'b1;
      rd("t2_pend", c_pend, 8'h00);

      // Masked source still pends, serviced once unmasked
      wr(c_mask, 8'h00);
      src = 8'h10;
      tick(1);
      src = 8'h00;
      push("t3_masked_irq", c_k_irq, 8'h00);
      tick(2);
      drain();
      rd("t3_pend", c_pend, 8'h10);
      wr(c_mask, 8'h10);
      exp_req("t3_unmask", 4'd4);
      tick(1);
      drain();
      iff1 = 1'b0;
      tick(1);
      wr(c_isr, 8'h00);
      iff1 = 1'b1;

      // Withdrawal by mask clear and by W1C
      wr(c_mask, 8'h01);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      exp_req("t4_req", 4'd0);
      tick(1);
      drain();
      wr(c_mask, 8'h00);
      push("t4_wd_irq", c_k_irq, 8'h00);
      drain();
      rd("t4_pend", c_pend, 8'h01);
      rd("t4_isr", c_isr, 8'h00);
      wr(c_mask, 8'h01);
      tick(1);
      push("t4_req2_irq", c_k_irq, 8'h01);
      drain();
      wr(c_pend, 8'h01);
      push("t4_w1c_irq", c_k_irq, 8'h00);
      drain();
      rd("t4_pend_clr", c_pend, 8'h00);

      // Level is not an edge; set beats W1C
      wr(c_mask, 8'h00);
      src = 8'h01;
      tick(10);
      rd("t5_level", c_pend, 8'h01);
      wr(c_pend, 8'h01);
      rd("t5_w1c", c_pend, 8'h00);
      src = 8'h00;
      tick(1);
      src = 8'h01;
      wr(c_pend, 8'h01);
      rd("t5_setwins", c_pend, 8'h01);
      src = 8'h00;

      // Async reset drops irq mid-REQ
      wr(c_mask, 8'h01);
      tick(1);
      push("t6_req_irq", c_k_irq, 8'h01);
      drain();
      reset = 1'b1;
      #2;
      push("t6_rst_req_irq", c_k_irq, 8'h00);
      drain();
      tick(1);
      reset = 1'b0;
      rd("t6_mask", c_mask, 8'h00);
      rd("t6_pend", c_pend, 8'h00);

      // Reset during SERVICE with src held high across reset
      wr(c_mask, 8'h01);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      tick(1);
      iff1 = 1'b0;
      tick(1);
      rd("t6_svc_isr", c_isr, 8'h80);
      iff1 = 1'b1;
      src = 8'h01;
      reset = 1'b1;
      #2;
      push("t6_rst_svc_irq", c_k_irq, 8'h00);
      drain();
      tick(2);
      reset = 1'b0;
      tick(2);
      rd("t6_post_mask", c_mask, 8'h00);
      rd("t6_post_pend", c_pend, 8'h00);
      rd("t6_post_isr", c_isr, 8'h00);
      push("t6_post_vect", c_k_vect, 8'h00);
      drain();
      wr(c_mask, 8'hFF);
      push("t6_no_spurious", c_k_irq, 8'h00);
      tick(2);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
